// File: rtl/frame_read_ctrl.sv
// Frame read scheduler: raster-reads the frame RAM into the filter chain, credit-paced by UART TX.
// Optional watchdog abort enabled by defining FRAME_CTRL_TIMEOUT_EN.
module frame_read_ctrl #(
    parameter int H_RES       = 170,
    parameter int V_RES       = 240,
    parameter int CREDITS     = 16,
    parameter int ADDR_W      = $clog2(H_RES * V_RES),
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_frame_done,
    input  logic              i_tx_done,
    input  logic              i_out_de,
    output logic              o_oe,
    output logic [ADDR_W-1:0] o_raddr,
    output logic              o_de,
    output logic              o_busy,
    output logic              o_frame_sent,
    output logic              o_drop,
    output logic              o_err,
    output logic [7:0]        o_frame_cnt
);

    localparam int NPIX  = H_RES * V_RES;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int CRD_W = $clog2(CREDITS + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NPIX - 1);
    localparam logic [CNT_W-1:0]  NPIX_CNT   = CNT_W'(NPIX);
    localparam logic [CRD_W-1:0]  CREDIT_MAX = CRD_W'(CREDITS);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [CRD_W-1:0]  credit_q, credit_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              de_q;
    logic              issue;
    logic              wd_fire;

    assign issue = (state_q == S_READ) && (credit_q != '0);

`ifdef FRAME_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);

    logic [WD_W-1:0] wd_q, wd_d;

    // Any forward progress (issue or a pixel leaving the chain) restarts the window.
    always_comb begin
        wd_d = wd_q + 1'b1;
        if (!o_busy || issue || i_out_de) begin
            wd_d = '0;
        end
    end

    assign wd_fire = o_busy && (wd_q == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        out_cnt_d    = out_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        o_frame_sent = 1'b0;
        o_drop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_frame_done) begin
                    state_d   = S_READ;
                    rd_addr_d = '0;
                    out_cnt_d = '0;
                end
            end
            S_READ: begin
                if (issue) begin
                    rd_addr_d = rd_addr_q + 1'b1;
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_cnt_q == NPIX_CNT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                o_frame_sent = 1'b1;
                frame_cnt_d  = frame_cnt_q + 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (i_frame_done && (state_q != S_IDLE)) begin
            o_drop = 1'b1;
        end
        if (o_busy && i_out_de) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end
        if (wd_fire) begin
            state_d = S_IDLE;
        end
    end

    // A returned byte and an issued pixel in the same cycle cancel; the count never exceeds the FIFO depth.
    always_comb begin
        credit_d = credit_q;
        if (wd_fire) begin
            credit_d = CREDIT_MAX;
        end else if (i_tx_done && !issue) begin
            if (credit_q != CREDIT_MAX) begin
                credit_d = credit_q + 1'b1;
            end
        end else if (issue && !i_tx_done) begin
            credit_d = credit_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            out_cnt_q   <= '0;
            credit_q    <= CREDIT_MAX;
            frame_cnt_q <= '0;
            de_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            out_cnt_q   <= out_cnt_d;
            credit_q    <= credit_d;
            frame_cnt_q <= frame_cnt_d;
            de_q        <= issue;
        end
    end

    assign o_oe        = issue;
    assign o_raddr     = issue ? rd_addr_q : '0;
    assign o_de        = de_q;
    assign o_busy      = (state_q == S_READ) || (state_q == S_DRAIN);
    assign o_err       = wd_fire;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_read_ctrl.sv
// Directed bench for frame_read_ctrl: scoreboard of read addresses plus credit/frame/drop/reset checks.
// Watchdog scenario runs only when FRAME_CTRL_TIMEOUT_EN is defined.
module tb_frame_read_ctrl;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int NP = H * V;
    localparam int CR = 4;
    localparam int TO = 50;
    localparam int AW = $clog2(NP);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_frame_done = 1'b0;
    logic          i_tx_done = 1'b0;
    logic          i_out_de = 1'b0;
    logic          o_oe;
    logic [AW-1:0] o_raddr;
    logic          o_de;
    logic          o_busy;
    logic          o_frame_sent;
    logic          o_drop;
    logic          o_err;
    logic [7:0]    o_frame_cnt;

    frame_read_ctrl #(
        .H_RES(H), .V_RES(V), .CREDITS(CR), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .i_frame_done(i_frame_done), .i_tx_done(i_tx_done), .i_out_de(i_out_de),
        .o_oe(o_oe), .o_raddr(o_raddr), .o_de(o_de), .o_busy(o_busy),
        .o_frame_sent(o_frame_sent), .o_drop(o_drop), .o_err(o_err),
        .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_q[$];
    int cyc = 0, issue_cnt = 0, first_issue_cyc = -1, last_issue_cyc = 0;
    int sent_cnt = 0, drop_cnt = 0, err_cnt = 0, err_cyc = 0;
    logic oe_seen = 1'b0, rst_seen = 1'b1;
    logic out_de_en = 1'b0;
    logic [5:0] pipe = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pop on every issue, o_de latency, event counters.
    always @(negedge clk) begin
        cyc++;
        chk("de_latency", o_de, rst_seen ? 1'b0 : oe_seen);
        oe_seen  = o_oe;
        rst_seen = reset;
        if (o_oe) begin
            issue_cnt++;
            if (first_issue_cyc < 0) first_issue_cyc = cyc;
            last_issue_cyc = cyc;
            chk("issue_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("raddr", o_raddr, exp_q.pop_front());
        end else begin
            chk("raddr_idle_zero", o_raddr, 0);
        end
        if (o_frame_sent) sent_cnt++;
        if (o_drop) drop_cnt++;
        if (o_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    // Chain model: o_de reappears as i_out_de a fixed number of cycles later.
    always @(posedge clk) begin
        #2;
        if (reset) pipe = '0;
        else pipe = {pipe[4:0], o_de};
        i_out_de = out_de_en & pipe[5];
    end

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int a = 0; a < NP; a++) exp_q.push_back(AW'(a));
    endtask

    task automatic start_frame();
        push_frame();
        i_frame_done = 1'b1;
        cyc_wait(1);
        i_frame_done = 1'b0;
    endtask

    task automatic wait_sent(input int target, input int bound);
        int n = 0;
        while (sent_cnt < target && n < bound) begin
            cyc_wait(1);
            n++;
        end
        chk("frame_sent_wait", sent_cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        cyc_wait(3);
        chk("rst_oe", o_oe, 0);
        chk("rst_raddr", o_raddr, 0);
        chk("rst_de", o_de, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_sent", o_frame_sent, 0);
        chk("rst_drop", o_drop, 0);
        chk("rst_err", o_err, 0);
        chk("rst_frame_cnt", o_frame_cnt, 0);
        reset = 1'b0;
        cyc_wait(1);

        // Full frame with a credit returned every cycle: back-to-back addresses.
        i_tx_done = 1'b1;
        out_de_en = 1'b1;
        issue_cnt = 0;
        first_issue_cyc = -1;
        start_frame();
        wait_sent(1, 100);
        chk("t1_issues", issue_cnt, NP);
        chk("t1_span", last_issue_cyc - first_issue_cyc, NP - 1);
        cyc_wait(5);
        chk("t1_single_sent", sent_cnt, 1);
        chk("t1_frame_cnt", o_frame_cnt, 1);
        chk("t1_idle", o_busy, 0);

        // TX completions at full credit in IDLE must not raise the credit.
        cyc_wait(10);
        i_tx_done = 1'b0;

        // Without returns only CR pixels may leave; one return allows exactly one more.
        issue_cnt = 0;
        start_frame();
        cyc_wait(12);
        chk("t2_credit_limit", issue_cnt, CR);
        chk("t2_oe_stalled", o_oe, 0);
        i_tx_done = 1'b1;
        cyc_wait(1);
        i_tx_done = 1'b0;
        cyc_wait(6);
        chk("t2_one_more", issue_cnt, CR + 1);

        // Two returns: the second coincides with an issue and must net zero.
        i_tx_done = 1'b1;
        cyc_wait(2);
        i_tx_done = 1'b0;
        cyc_wait(6);
        chk("t3_net_zero_c1", issue_cnt, CR + 3);
        i_tx_done = 1'b1;
        cyc_wait(5);
        i_tx_done = 1'b0;
        wait_sent(2, 100);
        chk("t2_issues", issue_cnt, NP);
        chk("t2_frame_cnt", o_frame_cnt, 2);

        // Credit 0 -> 2 in IDLE, then issue + return on the first READ cycle.
        i_tx_done = 1'b1;
        cyc_wait(2);
        i_tx_done = 1'b0;
        issue_cnt = 0;
        push_frame();
        i_frame_done = 1'b1;
        cyc_wait(1);
        i_frame_done = 1'b0;
        i_tx_done = 1'b1;
        cyc_wait(1);
        i_tx_done = 1'b0;
        cyc_wait(6);
        chk("t3_net_zero_c2", issue_cnt, 3);

        // A frame_done while reading is dropped and does not disturb the raster.
        drop_cnt = 0;
        i_tx_done = 1'b1;
        i_frame_done = 1'b1;
        cyc_wait(1);
        i_frame_done = 1'b0;
        wait_sent(3, 100);
        chk("t4_drop_pulse", drop_cnt, 1);
        cyc_wait(5);
        chk("t4_single_sent", sent_cnt, 3);
        chk("t4_frame_cnt", o_frame_cnt, 3);
        chk("t4_issues", issue_cnt, NP);
        chk("t4_queue_empty", exp_q.size(), 0);
        chk("t4_idle", o_busy, 0);

        // Reset while address 6 is on the bus, with credit already partly consumed.
        issue_cnt = 0;
        push_frame();
        i_frame_done = 1'b1;
        cyc_wait(1);
        i_frame_done = 1'b0;
        cyc_wait(4);
        i_tx_done = 1'b0;
        cyc_wait(2);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_addr_at_reset", o_raddr, 6);
        chk("t5_oe_at_reset", o_oe, 1);
        cyc_wait(1);
        reset = 1'b0;
        exp_q.delete();
        chk("t5_oe_after", o_oe, 0);
        chk("t5_busy_after", o_busy, 0);
        chk("t5_frame_cnt_cleared", o_frame_cnt, 0);
        cyc_wait(1);
        issue_cnt = 0;
        start_frame();
        cyc_wait(10);
        chk("t5_credit_reloaded", issue_cnt, CR);
        i_tx_done = 1'b1;
        wait_sent(4, 100);
        chk("t5_frame_cnt", o_frame_cnt, 1);
        chk("t5_queue_empty", exp_q.size(), 0);

`ifdef FRAME_CTRL_TIMEOUT_EN
        // Chain output withheld: watchdog must abort the drain.
        begin
            int n = 0;
            out_de_en = 1'b0;
            issue_cnt = 0;
            cyc_wait(3);
            start_frame();
            while (err_cnt < 1 && n < 200) begin
                cyc_wait(1);
                n++;
            end
            chk("t6_err_seen", err_cnt, 1);
            chk("t6_err_delay", err_cyc - last_issue_cyc, TO);
            chk("t6_issues", issue_cnt, NP);
            chk("t6_idle", o_busy, 0);
            chk("t6_frame_cnt", o_frame_cnt, 1);
            cyc_wait(3);
            chk("t6_no_sent", sent_cnt, 4);
        end
        chk("err_total", err_cnt, 1);
`else
        chk("err_total", err_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
